// File: rtl/nn_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : nn_mem_loader
// Description : Stream-to-BRAM loader that fills network memory (weights,
//               biases, inputs) from a valid/ready word stream ahead of a
//               neuron-calculation pass.
//               Optional macro NN_LOADER_CHECKSUM_EN adds a running checksum
//               and a trailer word that is compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module nn_mem_loader #(
    parameter  int ADDR_LEN = 4,
    parameter  int DATA_LEN = 32,
    localparam int AW       = (ADDR_LEN > 1) ? $clog2(ADDR_LEN) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [AW-1:0]       base_addr_i,
    input  logic [AW:0]         count_i,
    input  logic                abort_i,
    input  logic                s_valid_i,
    input  logic [DATA_LEN-1:0] s_data_i,
    output logic                s_ready_o,
    output logic                ram_wr_ena_o,
    output logic [AW-1:0]       ram_wr_addr_o,
    output logic [DATA_LEN-1:0] ram_wr_data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [31:0]         csum_o
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LOAD    = 2'd1;
    localparam logic [1:0] c_ST_TRAILER = 2'd2;

`ifdef NN_LOADER_CHECKSUM_EN
    localparam logic c_CSUM_EN = 1'b1;
`else
    localparam logic c_CSUM_EN = 1'b0;
`endif

    localparam logic [AW+1:0] c_DEPTH = ADDR_LEN[AW+1:0];
    localparam logic [AW:0]   c_ONE   = {{AW{1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [AW-1:0]       r_addr;
    logic [AW:0]         r_remain;
    logic                r_wr_ena;
    logic [AW-1:0]       r_wr_addr;
    logic [DATA_LEN-1:0] r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [31:0]         r_csum;

    logic                w_ready;
    logic                w_data_hs;
    logic                w_trl_hs;
    logic                w_start_acc;
    logic [AW+1:0]       w_end;
    logic                w_range_err;
    logic                w_empty;
    logic                w_last;
    logic                w_done_nxt;
    logic                w_busy_nxt;

    // Range check is done one bit wider than count so base+count cannot wrap.
    assign w_end       = {2'b00, base_addr_i} + {1'b0, count_i};
    assign w_range_err = (w_end > c_DEPTH);
    assign w_empty     = (count_i == '0);
    assign w_last      = (r_remain == c_ONE);
    assign w_start_acc = (r_state == c_ST_IDLE) && start_i && !abort_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_acc && !w_range_err) begin
                    if (w_empty) begin
                        w_state_nxt = c_CSUM_EN ? c_ST_TRAILER : c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_LOAD;
                    end
                end
            end
            c_ST_LOAD: begin
                if (abort_i) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_data_hs && w_last) begin
                    w_state_nxt = c_CSUM_EN ? c_ST_TRAILER : c_ST_IDLE;
                end
            end
            c_ST_TRAILER: begin
                if (abort_i || w_trl_hs) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- output / strobe logic ----------------
    // Abort gates ready combinationally so no word is consumed in the abort cycle.
    always_comb begin
        w_ready    = (r_state != c_ST_IDLE) && !abort_i;
        w_data_hs  = w_ready && s_valid_i && (r_state == c_ST_LOAD);
        w_trl_hs   = w_ready && s_valid_i && (r_state == c_ST_TRAILER);
        w_done_nxt = (w_start_acc && (w_range_err || (w_empty && !c_CSUM_EN)))
                   || (w_data_hs && w_last && !c_CSUM_EN)
                   || w_trl_hs;
        w_busy_nxt = w_start_acc || ((r_state != c_ST_IDLE) && !abort_i);
    end

    assign s_ready_o = w_ready;

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_addr    <= '0;
            r_remain  <= '0;
            r_wr_ena  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_csum    <= '0;
        end else begin
            r_wr_ena <= w_data_hs;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            if (w_start_acc) begin
                r_addr   <= base_addr_i;
                r_remain <= count_i;
                r_err    <= w_range_err;
                r_csum   <= '0;
            end else if (w_data_hs) begin
                r_wr_addr <= r_addr;
                r_wr_data <= s_data_i;
                r_addr    <= r_addr + 1'b1;
                r_remain  <= r_remain - 1'b1;
`ifdef NN_LOADER_CHECKSUM_EN
                r_csum    <= r_csum + 32'(s_data_i);
`endif
            end
`ifdef NN_LOADER_CHECKSUM_EN
            if (w_trl_hs) begin
                r_err <= (32'(s_data_i) != r_csum);
            end
`endif
        end
    end

    assign ram_wr_ena_o  = r_wr_ena;
    assign ram_wr_addr_o = r_wr_addr;
    assign ram_wr_data_o = r_wr_data;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign csum_o        = r_csum;

endmodule

`default_nettype wire

// File: tb/tb_nn_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_mem_loader
// Description : Scoreboard bench for nn_mem_loader; expected writes are queued
//               at each stream handshake and matched against BRAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_nn_mem_loader;

    localparam int ADDR_LEN = 4;
    localparam int DATA_LEN = 32;
    localparam int AW       = 2;

    logic                clk_i       = 1'b0;
    logic                reset_i     = 1'b1;
    logic                start_i     = 1'b0;
    logic [AW-1:0]       base_addr_i = '0;
    logic [AW:0]         count_i     = '0;
    logic                abort_i     = 1'b0;
    logic                s_valid_i   = 1'b0;
    logic [DATA_LEN-1:0] s_data_i    = '0;
    logic                s_ready_o;
    logic                ram_wr_ena_o;
    logic [AW-1:0]       ram_wr_addr_o;
    logic [DATA_LEN-1:0] ram_wr_data_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;
    logic [31:0]         csum_o;

    nn_mem_loader #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) u_dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .count_i       (count_i),
        .abort_i       (abort_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .ram_wr_ena_o  (ram_wr_ena_o),
        .ram_wr_addr_o (ram_wr_addr_o),
        .ram_wr_data_o (ram_wr_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .csum_o        (csum_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    bit ready_seen = 1'b0;

    typedef struct {
        int                  cyc;
        logic [AW-1:0]       addr;
        logic [DATA_LEN-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           e;
    logic [AW-1:0] m_addr   = '0;
    int            m_remain = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: a data handshake in cycle N must appear as a write in N+1.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (s_ready_o) ready_seen = 1'b1;
            if (done_o) done_cnt++;
            if (ram_wr_ena_o) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                    check("wr_addr", 64'(ram_wr_addr_o), 64'(e.addr));
                    check("wr_data", 64'(ram_wr_data_o), 64'(e.data));
                end
            end
            if (s_valid_i && s_ready_o && m_remain > 0) begin
                exp_q.push_back('{cyc + 1, m_addr, s_data_i});
                m_addr = m_addr + 1'b1;
                m_remain--;
            end
        end
    end

    task automatic start_pass(input logic [AW-1:0] base, input logic [AW:0] count);
        @(posedge clk_i); #1;
        start_i     = 1'b1;
        base_addr_i = base;
        count_i     = count;
        m_addr      = base;
        m_remain    = (int'(base) + int'(count) <= ADDR_LEN) ? int'(count) : 0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int t;
        t = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        @(negedge clk_i);
        while (!s_ready_o && t < 20) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            t++;
        end
        if (t >= 20) check("ready_timeout", 64'd0, 64'd1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
    endtask

    task automatic finish_pass(input logic exp_err, input logic [AW-1:0] last_addr,
                               input logic [31:0] sum);
`ifdef NN_LOADER_CHECKSUM_EN
        send_word(sum);
`endif
        @(negedge clk_i);
        check("done_pulse", 64'(done_o), 64'd1);
        check("done_err", 64'(err_o), 64'(exp_err));
        check("done_busy", 64'(busy_o), 64'd1);
`ifdef NN_LOADER_CHECKSUM_EN
        check("done_no_trailer_wr", 64'(ram_wr_ena_o), 64'd0);
        check("done_csum", 64'(csum_o), 64'(sum));
`else
        check("done_with_last_wr", 64'(ram_wr_ena_o), 64'd1);
        check("done_last_addr", 64'(ram_wr_addr_o), 64'(last_addr));
        check("csum_tied_zero", 64'(csum_o), 64'd0);
`endif
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("done_one_cycle", 64'(done_o), 64'd0);
        check("busy_drop", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
    endtask

    logic [31:0] w [4];
    logic [31:0] sum;

    initial begin
        w[0] = 32'h3F800000; w[1] = 32'h40000000;
        w[2] = 32'h40400000; w[3] = 32'h40800000;

        // Reset values
        @(negedge clk_i);
        check("rst_outputs", 64'({s_ready_o, ram_wr_ena_o, ram_wr_addr_o, busy_o, done_o, err_o}), 64'd0);
        check("rst_data_csum", {ram_wr_data_o, csum_o}, 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        // Full load, continuous valid
        wr_cnt = 0;
        start_pass(2'd0, 3'd4);
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i]);
            sum = sum + w[i];
        end
        finish_pass(1'b0, 2'd3, sum);
        check("full_wr_cnt", 64'(wr_cnt), 64'd4);

        // Stream bubbles: valid pattern 1,0,0,1
        wr_cnt = 0;
        start_pass(2'd1, 3'd2);
        send_word(w[1]);
        @(negedge clk_i);
        check("bubble_busy0", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("bubble_busy1", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;
        send_word(w[2]);
        finish_pass(1'b0, 2'd2, w[1] + w[2]);
        check("bubble_wr_cnt", 64'(wr_cnt), 64'd2);

        // Range error
        wr_cnt = 0; done_cnt = 0; ready_seen = 1'b0;
        start_pass(2'd3, 3'd2);
        @(negedge clk_i);
        check("range_done", 64'(done_o), 64'd1);
        check("range_err", 64'(err_o), 64'd1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        s_valid_i = 1'b0;
        check("range_no_ready", 64'(ready_seen), 64'd0);
        check("range_no_wr", 64'(wr_cnt), 64'd0);
        check("range_one_done", 64'(done_cnt), 64'd1);
        check("range_err_sticky", 64'(err_o), 64'd1);

        // Empty pass
        wr_cnt = 0;
        start_pass(2'd0, 3'd0);
`ifdef NN_LOADER_CHECKSUM_EN
        send_word(32'd0);
`endif
        @(negedge clk_i);
        check("empty_done", 64'(done_o), 64'd1);
        check("empty_err", 64'(err_o), 64'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("empty_no_wr", 64'(wr_cnt), 64'd0);

        // Abort after two handshakes, then a normal pass
        wr_cnt = 0; done_cnt = 0;
        start_pass(2'd0, 3'd4);
        send_word(w[0]);
        send_word(w[1]);
        abort_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = w[2];
        @(negedge clk_i);
        check("abort_ready_low", 64'(s_ready_o), 64'd0);
        @(posedge clk_i); #1;
        abort_i   = 1'b0;
        s_valid_i = 1'b0;
        @(negedge clk_i);
        check("abort_busy_low", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("abort_wr_cnt", 64'(wr_cnt), 64'd2);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        wr_cnt = 0;
        start_pass(2'd2, 3'd2);
        send_word(w[2]);
        send_word(w[3]);
        finish_pass(1'b0, 2'd3, w[2] + w[3]);
        check("post_abort_wr_cnt", 64'(wr_cnt), 64'd2);

`ifdef NN_LOADER_CHECKSUM_EN
        // Checksum trailer: good then bad
        for (int k = 0; k < 2; k++) begin
            wr_cnt = 0;
            start_pass(2'd0, 3'd3);
            send_word(32'd1);
            send_word(32'd2);
            send_word(32'd3);
            @(negedge clk_i);
            check("csum_value", 64'(csum_o), 64'd6);
            @(posedge clk_i); #1;
            send_word((k == 0) ? 32'd6 : 32'd7);
            @(negedge clk_i);
            check("csum_done", 64'(done_o), 64'd1);
            check("csum_err", 64'(err_o), (k == 0) ? 64'd0 : 64'd1);
            @(posedge clk_i); #1;
            check("csum_wr_cnt", 64'(wr_cnt), 64'd3);
        end
`endif

        // Reset in the middle of a pass
        start_pass(2'd0, 3'd4);
        send_word(w[0]);
        @(negedge clk_i);
        #1 reset_i = 1'b1;
        m_remain = 0;
        #1;
        check("midrst_outputs", 64'({s_ready_o, ram_wr_ena_o, busy_o, done_o, err_o}), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        repeat (3) begin @(posedge clk_i); #1; end
        check("midrst_idle", 64'({busy_o, done_o, s_ready_o}), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
